// File: rtl/sdrc_wb_arbiter_pkg.sv
// Shared types and constants for the SDRAM-side Wishbone arbiter.
// States, Wishbone cycle-type codes and arbitration-mode selectors.
package sdrc_wb_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

endpackage

// File: rtl/sdrc_wb_arbiter_rr_pick.sv
// Combinational winner select: round-robin scan from last+1, or lowest index
// when i_mode is high (fixed priority). Output is one-hot, zero if no request.
module sdrc_rr_pick #(
    parameter int NCH = 4,
    parameter int LW  = 2
) (
    input  logic [NCH-1:0] i_req,
    input  logic [LW-1:0]  i_last,
    input  logic           i_mode,
    output logic [NCH-1:0] o_win
);

    logic w_found;
    int   w_idx;

    always_comb begin
        o_win   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NCH; k++) begin
            w_idx = i_mode ? k : ((int'(i_last) + 1 + k) % NCH);
            if (i_req[w_idx] && !w_found) begin
                o_win[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdrc_wb_arbiter.sv
// NCH-master Wishbone arbiter in front of the SDRAM controller; grants whole cyc-to-cyc cycles.
// Optional ack timeout enabled with `define SDRC_WB_ARB_TIMEOUT_EN.
module sdrc_wb_arbiter
    import sdrc_wb_arb_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int SDR_DW   = 32,
    parameter int SDR_BW   = 4,
    parameter int APP_AW   = 26,
    parameter int ARB_MODE = 0,
    parameter int TMO_CYC  = 255
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic [NCH-1:0]        m_cyc_i,
    input  logic [NCH-1:0]        m_stb_i,
    input  logic [NCH-1:0]        m_we_i,
    input  logic [NCH*APP_AW-1:0] m_adr_i,
    input  logic [NCH*SDR_DW-1:0] m_dat_i,
    input  logic [NCH*SDR_BW-1:0] m_sel_i,
    input  logic [NCH*3-1:0]      m_cti_i,
    output logic [NCH-1:0]        m_ack_o,
    output logic [NCH-1:0]        m_err_o,
    output logic [SDR_DW-1:0]     m_dat_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [APP_AW-1:0]     s_adr_o,
    output logic [SDR_DW-1:0]     s_dat_o,
    output logic [SDR_BW-1:0]     s_sel_o,
    output logic [2:0]            s_cti_o,
    input  logic                  s_ack_i,
    input  logic [SDR_DW-1:0]     s_dat_i,
    output logic [NCH-1:0]        grant_o
);

    localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;

    arb_state_t     r_state, w_state_nxt;
    logic [NCH-1:0] r_grant, w_grant_nxt, w_win, w_req;
    logic [LW-1:0]  r_last, w_last_nxt, w_owner;
    logic           w_busy, w_tmo;

    always_comb begin
        w_owner = '0;
        for (int i = 0; i < NCH; i++)
            if (r_grant[i]) w_owner = LW'(i);
    end

    assign w_busy = (r_state == ARB_BUSY);

`ifdef SDRC_WB_ARB_TIMEOUT_EN
    logic [15:0]    r_tmo_cnt;
    logic [NCH-1:0] r_blk;

    assign w_tmo   = w_busy && (r_tmo_cnt == 16'(TMO_CYC));
    assign m_err_o = w_tmo ? r_grant : '0;
    // A timed-out master stays masked until it lets go of cyc.
    assign w_req   = m_cyc_i & ~r_blk;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_tmo_cnt <= '0;
            r_blk     <= '0;
        end else begin
            r_tmo_cnt <= (s_stb_o && !s_ack_i) ? r_tmo_cnt + 16'd1 : 16'd0;
            r_blk     <= (r_blk & m_cyc_i) | (w_tmo ? r_grant : '0);
        end
    end
`else
    assign w_tmo   = 1'b0;
    assign m_err_o = '0;
    assign w_req   = m_cyc_i;
`endif

    sdrc_rr_pick #(.NCH(NCH), .LW(LW)) u_pick (
        .i_req  (w_req),
        .i_last (r_last),
        .i_mode (ARB_MODE == ARB_FIXED),
        .o_win  (w_win)
    );

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_last  <= LW'(NCH - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        case (r_state)
            ARB_IDLE: begin
                if (|w_req) begin
                    w_state_nxt = ARB_BUSY;
                    w_grant_nxt = w_win;
                end
            end
            ARB_BUSY: begin
                if (!m_cyc_i[w_owner] || w_tmo) begin
                    w_state_nxt = ARB_IDLE;
                    w_grant_nxt = '0;
                    w_last_nxt  = w_owner;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Slave side follows the owner combinationally so a dropped cyc aborts immediately.
    always_comb begin
        s_cyc_o = w_busy && m_cyc_i[w_owner] && !w_tmo;
        s_stb_o = s_cyc_o && m_stb_i[w_owner];
        s_we_o  = w_busy && m_we_i[w_owner];
        s_adr_o = w_busy ? m_adr_i[int'(w_owner)*APP_AW +: APP_AW] : '0;
        s_dat_o = w_busy ? m_dat_i[int'(w_owner)*SDR_DW +: SDR_DW] : '0;
        s_sel_o = w_busy ? m_sel_i[int'(w_owner)*SDR_BW +: SDR_BW] : '0;
        s_cti_o = w_busy ? m_cti_i[int'(w_owner)*3 +: 3] : '0;
        m_ack_o = (s_cyc_o && s_ack_i) ? r_grant : '0;
        m_dat_o = w_busy ? s_dat_i : '0;
    end

    assign grant_o = r_grant;

endmodule

// File: tb/tb_sdrc_wb_arbiter.sv
// Directed bench for sdrc_wb_arbiter: a round-robin and a fixed-priority instance share stimulus.
module tb_sdrc_wb_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int AW  = 26;

    logic              sys_clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    m_cyc_i, m_stb_i, m_we_i;
    logic [NCH*AW-1:0] m_adr_i;
    logic [NCH*DW-1:0] m_dat_i;
    logic [NCH*BW-1:0] m_sel_i;
    logic [NCH*3-1:0]  m_cti_i;
    logic              s_ack_i;
    logic [DW-1:0]     s_dat_i;

    logic [NCH-1:0] m_ack_o, m_err_o, grant_o;
    logic [DW-1:0]  m_dat_o, s_dat_o;
    logic           s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]  s_adr_o;
    logic [BW-1:0]  s_sel_o;
    logic [2:0]     s_cti_o;

    logic [NCH-1:0] f_ack, f_err, f_grant;
    logic [DW-1:0]  f_mdat, f_sdat;
    logic           f_cyc, f_stb, f_we;
    logic [AW-1:0]  f_adr;
    logic [BW-1:0]  f_sel;
    logic [2:0]     f_cti;

    int n_checks = 0;
    int n_errors = 0;

    always #5 sys_clk = ~sys_clk;

    sdrc_wb_arbiter #(.NCH(NCH), .SDR_DW(DW), .SDR_BW(BW), .APP_AW(AW), .ARB_MODE(0)
`ifdef SDRC_WB_ARB_TIMEOUT_EN
        , .TMO_CYC(16)
`endif
    ) u_rr (
        .sys_clk(sys_clk), .reset(reset),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i),
        .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_cti_i(m_cti_i),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .grant_o(grant_o)
    );

    sdrc_wb_arbiter #(.NCH(NCH), .SDR_DW(DW), .SDR_BW(BW), .APP_AW(AW), .ARB_MODE(1)) u_fx (
        .sys_clk(sys_clk), .reset(reset),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i),
        .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_cti_i(m_cti_i),
        .m_ack_o(f_ack), .m_err_o(f_err), .m_dat_o(f_mdat),
        .s_cyc_o(f_cyc), .s_stb_o(f_stb), .s_we_o(f_we), .s_adr_o(f_adr),
        .s_dat_o(f_sdat), .s_sel_o(f_sel), .s_cti_o(f_cti),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .grant_o(f_grant)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_cti_i = '0;
        s_ack_i = 1'b0;
        s_dat_i = 32'hDEAD_BEEF;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (grant_o !== 4'b0000) begin
            n_errors++; $display("FAIL reset_grant actual=%b expected=0000", grant_o);
        end
        n_checks++;
        if ({s_cyc_o, s_stb_o, s_we_o, m_ack_o, m_err_o} !== 11'b0) begin
            n_errors++; $display("FAIL reset_ctrl actual=%b expected=0", {s_cyc_o, s_stb_o, s_we_o, m_ack_o, m_err_o});
        end
        n_checks++;
        if (m_dat_o !== 32'h0 || s_adr_o !== 26'h0) begin
            n_errors++; $display("FAIL reset_data actual=%h/%h expected=0/0", m_dat_o, s_adr_o);
        end
    endtask

    task automatic test_single();
        int acks = 0;
        do_reset();
        m_cyc_i[2] = 1'b1; m_stb_i[2] = 1'b1; m_we_i[2] = 1'b1;
        m_adr_i[2*AW +: AW] = 26'h123456;
        m_dat_i[2*DW +: DW] = 32'hA5A5_0002;
        m_sel_i[2*BW +: BW] = 4'hF;
        m_cti_i[2*3 +: 3]   = 3'b010;
        #1;
        n_checks++;
        if (s_cyc_o !== 1'b0) begin
            n_errors++; $display("FAIL single_latency actual=%b expected=0", s_cyc_o);
        end
        tick();
        n_checks++;
        if (grant_o !== 4'b0100 || s_cyc_o !== 1'b1 || s_we_o !== 1'b1) begin
            n_errors++; $display("FAIL single_grant actual=%b cyc=%b we=%b expected=0100 1 1", grant_o, s_cyc_o, s_we_o);
        end
        n_checks++;
        if (s_adr_o !== 26'h123456 || s_dat_o !== 32'hA5A5_0002 || s_sel_o !== 4'hF || s_cti_o !== 3'b010) begin
            n_errors++; $display("FAIL single_mux actual=%h %h %h %b expected=123456 a5a50002 f 010", s_adr_o, s_dat_o, s_sel_o, s_cti_o);
        end
        for (int i = 0; i < 4; i++) begin
            s_ack_i = 1'b1;
            #1;
            if (m_ack_o == 4'b0100) acks++;
            n_checks++;
            if (m_ack_o !== 4'b0100 || m_err_o !== 4'b0000) begin
                n_errors++; $display("FAIL single_ack beat=%0d actual=%b err=%b expected=0100 0000", i, m_ack_o, m_err_o);
            end
            tick();
        end
        s_ack_i = 1'b0;
        n_checks++;
        if (acks != 4) begin
            n_errors++; $display("FAIL single_ack_count actual=%0d expected=4", acks);
        end
        m_cyc_i = '0; m_stb_i = '0;
        #1;
        n_checks++;
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
            n_errors++; $display("FAIL single_release actual=%b%b expected=00", s_cyc_o, s_stb_o);
        end
        tick();
        n_checks++;
        if (grant_o !== 4'b0000) begin
            n_errors++; $display("FAIL single_idle actual=%b expected=0000", grant_o);
        end
    endtask

    task automatic test_rr_fairness();
        int exp_ch[5] = '{0, 1, 2, 3, 0};
        do_reset();
        m_cyc_i = 4'b1111; m_stb_i = 4'b1111;
        tick();
        for (int n = 0; n < 5; n++) begin
            logic [NCH-1:0] exp_oh;
            exp_oh = 4'b0001 << exp_ch[n];
            n_checks++;
            if (grant_o !== exp_oh || s_cyc_o !== 1'b1) begin
                n_errors++; $display("FAIL rr_grant turn=%0d actual=%b cyc=%b expected=%b 1", n, grant_o, s_cyc_o, exp_oh);
            end
            s_ack_i = 1'b1;
            #1;
            n_checks++;
            if (m_ack_o !== exp_oh) begin
                n_errors++; $display("FAIL rr_ack turn=%0d actual=%b expected=%b", n, m_ack_o, exp_oh);
            end
            tick();
            s_ack_i = 1'b0;
            m_cyc_i[exp_ch[n]] = 1'b0; m_stb_i[exp_ch[n]] = 1'b0;
            tick();
            n_checks++;
            if (grant_o !== 4'b0000 || s_cyc_o !== 1'b0) begin
                n_errors++; $display("FAIL rr_gap turn=%0d actual=%b cyc=%b expected=0000 0", n, grant_o, s_cyc_o);
            end
            m_cyc_i[exp_ch[n]] = 1'b1; m_stb_i[exp_ch[n]] = 1'b1;
            tick();
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_fixed();
        do_reset();
        m_cyc_i = 4'b1010; m_stb_i = 4'b1010;
        tick();
        n_checks++;
        if (f_grant !== 4'b0010) begin
            n_errors++; $display("FAIL fixed_first actual=%b expected=0010", f_grant);
        end
        m_cyc_i = 4'b1011; m_stb_i = 4'b1011;
        tick();
        tick();
        n_checks++;
        if (f_grant !== 4'b0010) begin
            n_errors++; $display("FAIL fixed_nopreempt actual=%b expected=0010", f_grant);
        end
        m_cyc_i = 4'b1000; m_stb_i = 4'b1000;
        tick();
        n_checks++;
        if (f_grant !== 4'b0000 || f_cyc !== 1'b0) begin
            n_errors++; $display("FAIL fixed_gap actual=%b cyc=%b expected=0000 0", f_grant, f_cyc);
        end
        tick();
        n_checks++;
        if (f_grant !== 4'b1000 || f_cyc !== 1'b1) begin
            n_errors++; $display("FAIL fixed_second actual=%b cyc=%b expected=1000 1", f_grant, f_cyc);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_burst_read();
        do_reset();
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
        m_adr_i[0 +: AW] = 26'h0000100;
        m_cti_i[0 +: 3]  = 3'b010;
        tick();
        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] exp_dat;
            logic [2:0]    exp_cti;
            exp_dat = 32'hC0DE_0000 + 32'(i);
            exp_cti = (i == 7) ? 3'b111 : 3'b010;
            m_cti_i[0 +: 3] = exp_cti;
            s_dat_i = exp_dat;
            s_ack_i = 1'b1;
            #1;
            n_checks++;
            if (m_dat_o !== exp_dat || m_ack_o !== 4'b0001 || s_cti_o !== exp_cti || s_we_o !== 1'b0) begin
                n_errors++; $display("FAIL burst_beat beat=%0d actual=%h ack=%b cti=%b we=%b expected=%h 0001 %b 0",
                                     i, m_dat_o, m_ack_o, s_cti_o, s_we_o, exp_dat, exp_cti);
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_abort_reset();
        do_reset();
        m_cyc_i[2] = 1'b1; m_stb_i[2] = 1'b1;
        m_cti_i[2*3 +: 3] = 3'b010;
        tick();
        s_ack_i = 1'b1;
        tick();
        s_ack_i = 1'b0;
        m_cyc_i[2] = 1'b0;
        #1;
        n_checks++;
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
            n_errors++; $display("FAIL abort_drop actual=%b%b expected=00", s_cyc_o, s_stb_o);
        end
        tick();
        s_ack_i = 1'b1;
        #1;
        n_checks++;
        if (m_ack_o !== 4'b0000 || grant_o !== 4'b0000) begin
            n_errors++; $display("FAIL abort_late_ack actual=%b grant=%b expected=0000 0000", m_ack_o, grant_o);
        end
        s_ack_i = 1'b0; m_stb_i = '0;
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1;
        tick();
        n_checks++;
        if (grant_o !== 4'b0010) begin
            n_errors++; $display("FAIL abort_regrant actual=%b expected=0010", grant_o);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (grant_o !== 4'b0000 || s_cyc_o !== 1'b0) begin
            n_errors++; $display("FAIL reset_in_busy actual=%b cyc=%b expected=0000 0", grant_o, s_cyc_o);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (grant_o !== 4'b0010 || s_cyc_o !== 1'b1) begin
            n_errors++; $display("FAIL reset_recover actual=%b cyc=%b expected=0010 1", grant_o, s_cyc_o);
        end
        clear_inputs();
        tick();
    endtask

`ifdef SDRC_WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int k = 0;
        bit seen = 1'b0;
        do_reset();
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
        tick();
        while (!seen && k < 40) begin
            if (m_err_o !== 4'b0000) seen = 1'b1;
            else begin
                tick();
                k++;
            end
        end
        n_checks++;
        if (!seen || k != 16 || m_err_o !== 4'b0001 || s_cyc_o !== 1'b0) begin
            n_errors++; $display("FAIL timeout_pulse cycle=%0d err=%b cyc=%b expected=16 0001 0", k, m_err_o, s_cyc_o);
        end
        tick();
        tick();
        n_checks++;
        if (grant_o !== 4'b0000 || m_err_o !== 4'b0000) begin
            n_errors++; $display("FAIL timeout_blocked actual=%b err=%b expected=0000 0000", grant_o, m_err_o);
        end
        m_cyc_i[0] = 1'b0;
        tick();
        m_cyc_i[0] = 1'b1;
        tick();
        n_checks++;
        if (grant_o !== 4'b0001) begin
            n_errors++; $display("FAIL timeout_regrant actual=%b expected=0001", grant_o);
        end
        clear_inputs();
        tick();
    endtask
`endif

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_rr_fairness();
        test_fixed();
        test_burst_read();
        test_abort_reset();
`ifdef SDRC_WB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
